// File: rtl/bias_act_stage.sv
// rtl/bias_act_stage.sv - bias add with saturation and hard activation on a captured dot_prod result vector
// One element per cycle through a 2-stage pipeline; the full vector is held for the consumer until outAck.
module bias_act_stage #(
    parameter int NROW     = 32,
    parameter int QN       = 6,
    parameter int QM       = 11,
    parameter int ACT_TYPE = 0,
    localparam int BITWIDTH = QN + QM + 1,
    localparam int VEC_W    = BITWIDTH * NROW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             dataReady,
    input  logic [VEC_W-1:0] dotVec,
    input  logic [VEC_W-1:0] biasVec,
    input  logic             outAck,
    output logic             busy,
    output logic             outValid,
    output logic [VEC_W-1:0] outVec,
    output logic             overrun
);

    localparam int AW = (NROW > 1) ? $clog2(NROW) : 1;
    localparam logic [AW-1:0] LAST = AW'(NROW - 1);

    localparam logic signed [BITWIDTH-1:0] SAT_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [BITWIDTH-1:0] SAT_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic signed [BITWIDTH-1:0] ONE     = BITWIDTH'(1 << QM);
    localparam logic signed [BITWIDTH-1:0] NEG_ONE = -ONE;
    localparam logic signed [BITWIDTH:0]   ONE_W   = (BITWIDTH+1)'(1 << QM);
    localparam logic signed [BITWIDTH:0]   HALF_W  = (BITWIDTH+1)'(1 << (QM - 1));

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateType;

    stateType state;
    logic [AW-1:0] idx;
    logic issuing;
    logic s1Valid;
    logic [AW-1:0] s1Idx;
    logic signed [BITWIDTH-1:0] s1Sum;

    logic signed [BITWIDTH-1:0] xMem   [NROW];
    logic signed [BITWIDTH-1:0] bMem   [NROW];
    logic signed [BITWIDTH-1:0] outMem [NROW];

    logic acceptNew;

    function automatic logic signed [BITWIDTH-1:0] satAdd(
        input logic signed [BITWIDTH-1:0] a,
        input logic signed [BITWIDTH-1:0] b
    );
        logic signed [BITWIDTH:0] s;
        s = {a[BITWIDTH-1], a} + {b[BITWIDTH-1], b};
        if (s[BITWIDTH] != s[BITWIDTH-1])
            return s[BITWIDTH] ? SAT_MIN : SAT_MAX;
        return s[BITWIDTH-1:0];
    endfunction

    function automatic logic signed [BITWIDTH-1:0] activate(input logic signed [BITWIDTH-1:0] s);
        logic signed [BITWIDTH:0] t;
        logic signed [BITWIDTH-1:0] y;
        t = '0;
        y = s;
        if (ACT_TYPE == 0) begin
            // arithmetic shift floors toward -inf, which the sigmoid slope relies on
            t = $signed({s[BITWIDTH-1], s}) >>> 2;
            t = t + HALF_W;
            if (t < 0)
                y = '0;
            else if (t > ONE_W)
                y = ONE;
            else
                y = t[BITWIDTH-1:0];
        end else if (ACT_TYPE == 1) begin
            if (s > ONE)
                y = ONE;
            else if (s < NEG_ONE)
                y = NEG_ONE;
            else
                y = s;
        end
        return y;
    endfunction

    assign acceptNew = dataReady && ((state == IDLE) || (state == DONE && outAck));

    always_ff @(posedge clock) begin
        if (acceptNew) begin
            for (int i = 0; i < NROW; i++) begin
                xMem[i] <= dotVec[i*BITWIDTH +: BITWIDTH];
                bMem[i] <= biasVec[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            issuing  <= 1'b0;
            s1Valid  <= 1'b0;
            s1Idx    <= '0;
            s1Sum    <= '0;
            busy     <= 1'b0;
            outValid <= 1'b0;
            overrun  <= 1'b0;
            for (int i = 0; i < NROW; i++)
                outMem[i] <= '0;
        end else begin
            overrun <= 1'b0;
            s1Valid <= 1'b0;

            if (state == RUN && issuing) begin
                s1Valid <= 1'b1;
                s1Idx   <= idx;
                s1Sum   <= satAdd(xMem[idx], bMem[idx]);
                idx     <= idx + AW'(1);
                if (idx == LAST)
                    issuing <= 1'b0;
            end

            // last slot write and outValid land on the same edge
            if (s1Valid) begin
                outMem[s1Idx] <= activate(s1Sum);
                if (s1Idx == LAST) begin
                    outValid <= 1'b1;
                    state    <= DONE;
                end
            end

            case (state)
                IDLE: begin
                    if (dataReady) begin
                        idx     <= '0;
                        issuing <= 1'b1;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (dataReady)
                        overrun <= 1'b1;
                end
                DONE: begin
                    if (outAck) begin
                        outValid <= 1'b0;
                        if (dataReady) begin
                            idx     <= '0;
                            issuing <= 1'b1;
                            state   <= RUN;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (dataReady) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NROW; g++) begin : g_pack
        assign outVec[g*BITWIDTH +: BITWIDTH] = outMem[g];
    end

endmodule
